// File: rtl/seg7_scan_counter.sv
// Hex up/down counter with a prescaled tick and a multiplexed 7-segment scan.
// Optional build macro LZ_BLANK_EN blanks leading-zero digits.
module seg7_scan_counter #(
  parameter int TICK_DIV = 10000000,
  parameter int SCAN_DIV = 1000,
  parameter int DIGITS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                up,
  input  logic                clr,
  output logic [4*DIGITS-1:0] value,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                tick,
  output logic                wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int VW = 4 * DIGITS;

  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [1:0]    IDX_MAX  = 2'(DIGITS - 1);

  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_scan;
  logic [1:0]    r_idx;
  logic [VW-1:0] r_value;
  logic          r_tick;
  logic          r_wrap;

  logic          w_event;
  logic          w_wrap;
  logic [VW-1:0] w_next;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_event = run && (r_pre == PRE_MAX);
  assign w_next  = up ? r_value + VW'(1)
                      : r_value - VW'(1);
  assign w_wrap  = up ? (r_value == '1)
                      : (r_value == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_value <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_pre   <= '0;
      r_value <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_tick <= w_event;
      r_wrap <= w_event && w_wrap;
      if (run)
        r_pre <= w_event ? '0 : r_pre + PW'(1);
      if (w_event)
        r_value <= w_next;
    end
  end

  // Scan runs free of run/clr so the display never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (r_scan == SCAN_MAX) begin
      r_scan <= '0;
      r_idx  <= (r_idx == IDX_MAX) ? 2'd0
                                   : r_idx + 2'd1;
    end else begin
      r_scan <= r_scan + SW'(1);
    end
  end

  always_comb begin
    w_nib = 4'h0;
    for (int i = 0; i < DIGITS; i++)
      if (r_idx == 2'(i))
        w_nib = r_value[4*i +: 4];
  end

  assign w_seg = hex7(w_nib);

`ifdef LZ_BLANK_EN
  logic w_blank;

  always_comb begin
    w_blank = (r_idx != 2'd0);
    for (int i = 0; i < DIGITS; i++)
      if ((2'(i) >= r_idx) && (r_value[4*i +: 4] != 4'h0))
        w_blank = 1'b0;
  end

  assign seg = w_blank ? 7'h00 : w_seg;
`else
  assign seg = w_seg;
`endif

  assign dig_sel = DIGITS'(1) << r_idx;
  assign value   = r_value;
  assign tick    = r_tick;
  assign wrap    = r_wrap;

endmodule
